// File: rtl/fetch_unit.sv
// Instruction-fetch front end: issues req/ack fetches into a small FIFO and presents the head
// word to decode, honouring the decode stall and flushing/refetching on a redirect.
module fetch_unit #(
   parameter int unsigned PC_LEN   = 16,
   parameter int unsigned WORD_LEN = 16,
   parameter int unsigned DEPTH    = 2
) (
   input  logic                clk,
   input  logic                rst,
   output logic                imem_req,
   output logic [PC_LEN-1:0]   imem_addr,
   input  logic                imem_ack,
   input  logic [WORD_LEN-1:0] imem_rdata,
   input  logic                hazard_detected,
   input  logic                redirect,
   input  logic [PC_LEN-1:0]   redirect_pc,
   output logic                instr_valid,
   output logic [WORD_LEN-1:0] instruction,
   output logic [PC_LEN-1:0]   instr_pc
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   typedef enum logic [0:0] {StFetch, StDrop} state_t;

   state_t              r_state;
   logic [PC_LEN-1:0]   r_fetch_pc;
   logic                r_req;
   logic [PC_LEN-1:0]   r_addr;
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [CNT_W-1:0]    r_count;
   logic [PC_LEN-1:0]   r_pc_mem   [DEPTH];
   logic [WORD_LEN-1:0] r_word_mem [DEPTH];

   logic w_ack;
   logic w_valid;
   logic w_push;
   logic w_pop;
   logic w_start;

   // A stray ack with no request in flight is ignored.
   assign w_ack   = r_req && imem_ack;
   assign w_valid = (r_count != '0);
   assign w_push  = w_ack && (r_state == StFetch) && !redirect;
   assign w_pop   = w_valid && !hazard_detected && !redirect;
   assign w_start = !r_req && (r_state == StFetch) && !redirect && (r_count < DEPTH_C);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= StFetch;
         r_fetch_pc <= '0;
         r_req      <= 1'b0;
         r_addr     <= '0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
      end else begin
         if (redirect) begin
            r_fetch_pc <= redirect_pc;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            // An unfinished request cannot be withdrawn; its data must be swallowed later.
            r_state    <= (r_req && !imem_ack) ? StDrop : StFetch;
         end else begin
            if (w_push) begin
               r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
               r_fetch_pc <= r_fetch_pc + PC_LEN'(1);
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            unique case ({w_push, w_pop})
               2'b10:   r_count <= r_count + CNT_W'(1);
               2'b01:   r_count <= r_count - CNT_W'(1);
               default: ;
            endcase
            if ((r_state == StDrop) && w_ack) begin
               r_state <= StFetch;
            end
         end

         if (w_ack) begin
            r_req <= 1'b0;
         end else if (w_start) begin
            r_req  <= 1'b1;
            r_addr <= r_fetch_pc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_pc_mem[r_wr_ptr]   <= r_fetch_pc;
         r_word_mem[r_wr_ptr] <= imem_rdata;
      end
   end

   assign imem_req    = r_req;
   assign imem_addr   = r_addr;
   assign instr_valid = w_valid;
   assign instruction = w_valid ? r_word_mem[r_rd_ptr] : '0;
   assign instr_pc    = w_valid ? r_pc_mem[r_rd_ptr] : '0;

   a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
                                    w_push |-> (r_count != DEPTH_C));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed table, corner sequences and a randomized run
// compared every cycle against a queue-based reference model.
module tb_fetch_unit;

   localparam int PC_LEN   = 16;
   localparam int WORD_LEN = 16;
   localparam int DEPTH    = 2;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic                imem_req;
   logic [PC_LEN-1:0]   imem_addr;
   logic                imem_ack = 1'b0;
   logic [WORD_LEN-1:0] imem_rdata = '0;
   logic                hazard_detected = 1'b0;
   logic                redirect = 1'b0;
   logic [PC_LEN-1:0]   redirect_pc = '0;
   logic                instr_valid;
   logic [WORD_LEN-1:0] instruction;
   logic [PC_LEN-1:0]   instr_pc;

   always #5 clk = ~clk;

   fetch_unit #(.PC_LEN(PC_LEN), .WORD_LEN(WORD_LEN), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .hazard_detected(hazard_detected),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instruction    (instruction),
      .instr_pc       (instr_pc)
   );

   // Reference model: buffered words as a queue, plus the single fetch in flight.
   typedef struct {
      logic [15:0] pc;
      logic [15:0] word;
   } entry_t;

   entry_t      mq[$];
   logic [15:0] m_fpc;
   logic [15:0] m_oaddr;
   logic        m_out;
   logic        m_drop;

   int unsigned mem_wait;
   int unsigned mem_cnt;
   logic        mem_rand;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_fpc   = '0;
      m_oaddr = '0;
      m_out   = 1'b0;
      m_drop  = 1'b0;
      mem_cnt = 0;
   endtask

   task automatic model_step();
      int     n;
      logic   ack;
      logic   start;
      entry_t e;
      n     = mq.size();
      ack   = m_out && imem_ack;
      start = !m_out && !redirect && (n < DEPTH);
      if (redirect) begin
         mq.delete();
         m_fpc  = redirect_pc;
         m_drop = m_out && !ack;
      end else begin
         if (n != 0 && !hazard_detected) void'(mq.pop_front());
         if (ack && !m_drop) begin
            e.pc   = m_fpc;
            e.word = imem_rdata;
            mq.push_back(e);
            m_fpc = 16'(m_fpc + 16'd1);
         end
         if (ack) m_drop = 1'b0;
      end
      if (ack) begin
         m_out = 1'b0;
      end else if (start) begin
         m_out   = 1'b1;
         m_oaddr = m_fpc;
      end
   endtask

   task automatic check_model();
      logic        ev;
      logic [15:0] ei;
      logic [15:0] ep;
      ev = (mq.size() != 0);
      ei = ev ? mq[0].word : 16'h0000;
      ep = ev ? mq[0].pc : 16'h0000;
      chk("imem_req", 32'(imem_req), 32'(m_out));
      if (m_out) chk("imem_addr", 32'(imem_addr), 32'(m_oaddr));
      chk("instr_valid", 32'(instr_valid), 32'(ev));
      chk("instruction", 32'(instruction), 32'(ei));
      chk("instr_pc", 32'(instr_pc), 32'(ep));
   endtask

   // One clock: drive inputs in the low phase, check, then advance model and memory.
   task automatic cycle(input logic hz, input logic rd, input logic [15:0] rpc);
      @(negedge clk);
      hazard_detected = hz;
      redirect        = rd;
      redirect_pc     = rpc;
      if (imem_req && mem_cnt >= mem_wait) begin
         imem_ack   = 1'b1;
         imem_rdata = 16'(imem_addr + 16'h1000);
      end else begin
         imem_ack   = 1'b0;
         imem_rdata = 16'($urandom);
      end
      #1;
      check_model();
      model_step();
      if (imem_req) begin
         if (imem_ack) begin
            mem_cnt = 0;
            if (mem_rand) mem_wait = $urandom_range(0, 3);
         end else begin
            mem_cnt++;
         end
      end else begin
         mem_cnt = 0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst             = 1'b0;
      hazard_detected = 1'b0;
      redirect        = 1'b0;
      imem_ack        = 1'b0;
      #2;
      model_reset();
      chk("reset_req", 32'(imem_req), 32'd0);
      chk("reset_addr", 32'(imem_addr), 32'd0);
      chk("reset_valid", 32'(instr_valid), 32'd0);
      chk("reset_instr", 32'(instruction), 32'd0);
      chk("reset_pc", 32'(instr_pc), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      model_step();
   endtask

   typedef struct {
      logic        hz;
      logic        exp_req;
      logic [15:0] exp_addr;
      logic        exp_valid;
      logic [15:0] exp_instr;
      logic [15:0] exp_pc;
   } vec_t;

   vec_t vecs[6];

   initial begin
      logic [15:0] held_i;
      logic [15:0] held_p;
      logic [15:0] seen[$];
      logic [15:0] reqs[$];
      logic        got;
      int          bad;

      // Zero-wait stream after reset: one fetch every two cycles.
      vecs[0] = '{1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000};
      vecs[1] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h1000, 16'h0000};
      vecs[2] = '{1'b0, 1'b1, 16'h0001, 1'b0, 16'h0000, 16'h0000};
      vecs[3] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h1001, 16'h0001};
      vecs[4] = '{1'b0, 1'b1, 16'h0002, 1'b0, 16'h0000, 16'h0000};
      vecs[5] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h1002, 16'h0002};

      mem_rand = 1'b0;
      mem_wait = 0;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         cycle(vecs[i].hz, 1'b0, 16'h0000);
         chk("vec_req", 32'(imem_req), 32'(vecs[i].exp_req));
         if (vecs[i].exp_req) chk("vec_addr", 32'(imem_addr), 32'(vecs[i].exp_addr));
         chk("vec_valid", 32'(instr_valid), 32'(vecs[i].exp_valid));
         chk("vec_instr", 32'(instruction), 32'(vecs[i].exp_instr));
         chk("vec_pc", 32'(instr_pc), 32'(vecs[i].exp_pc));
      end

      // Stall with a full FIFO, then drain in order.
      do_reset();
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 16'h0000);
      chk("full_valid", 32'(instr_valid), 32'd1);
      chk("full_pc", 32'(instr_pc), 32'd0);
      held_i = instruction;
      held_p = instr_pc;
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 1'b0, 16'h0000);
         chk("stall_instr", 32'(instruction), 32'(held_i));
         chk("stall_pc", 32'(instr_pc), 32'(held_p));
         chk("stall_noreq", 32'(imem_req), 32'd0);
      end
      seen.delete();
      for (int i = 0; i < 8; i++) begin
         cycle(1'b0, 1'b0, 16'h0000);
         if (instr_valid) seen.push_back(instr_pc);
      end
      chk("drain_count", 32'(seen.size() >= 3), 32'd1);
      if (seen.size() >= 3) begin
         chk("drain_0", 32'(seen[0]), 32'h0000);
         chk("drain_1", 32'(seen[1]), 32'h0001);
         chk("drain_2", 32'(seen[2]), 32'h0002);
      end

      // 3 wait states, redirect in the second wait cycle.
      mem_wait = 3;
      do_reset();
      cycle(1'b0, 1'b0, 16'h0000);
      cycle(1'b0, 1'b1, 16'h0040);
      got = 1'b0;
      bad = 0;
      reqs.delete();
      for (int i = 0; i < 30; i++) begin
         cycle(1'b0, 1'b0, 16'h0000);
         if (imem_req && imem_addr != 16'h0000 && reqs.size() == 0) reqs.push_back(imem_addr);
         if (instr_valid && !got) begin
            got = 1'b1;
            chk("drop_first_pc", 32'(instr_pc), 32'h0040);
            chk("drop_first_word", 32'(instruction), 32'h1040);
         end
         if (instr_valid && instr_pc == 16'h0000) bad++;
      end
      chk("drop_got_valid", 32'(got), 32'd1);
      chk("drop_new_addr", 32'(reqs.size() == 1 ? reqs[0] : 16'hDEAD), 32'h0040);
      chk("drop_no_stale", 32'(bad), 32'd0);

      // Redirect together with hazard while two entries are buffered.
      mem_wait = 0;
      do_reset();
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 16'h0000);
      cycle(1'b1, 1'b1, 16'h0080);
      cycle(1'b0, 1'b0, 16'h0000);
      chk("flush_valid", 32'(instr_valid), 32'd0);
      chk("flush_instr", 32'(instruction), 32'd0);
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         cycle(1'b0, 1'b0, 16'h0000);
         if (instr_valid) begin
            got = 1'b1;
            chk("flush_refetch_pc", 32'(instr_pc), 32'h0080);
         end
      end
      chk("flush_refetch_seen", 32'(got), 32'd1);

      // Back-to-back redirects while an old request is still in flight.
      mem_wait = 3;
      do_reset();
      cycle(1'b0, 1'b0, 16'h0000);
      cycle(1'b0, 1'b1, 16'h0010);
      cycle(1'b0, 1'b1, 16'h0020);
      got = 1'b0;
      bad = 0;
      for (int i = 0; i < 30; i++) begin
         cycle(1'b0, 1'b0, 16'h0000);
         if (imem_req && imem_addr == 16'h0010) bad++;
         if (instr_valid && instr_pc == 16'h0010) bad++;
         if (instr_valid && !got) begin
            got = 1'b1;
            chk("dbl_first_pc", 32'(instr_pc), 32'h0020);
         end
      end
      chk("dbl_got_valid", 32'(got), 32'd1);
      chk("dbl_no_0x10", 32'(bad), 32'd0);

      // PC wrap from 0xFFFF.
      mem_wait = 0;
      do_reset();
      cycle(1'b0, 1'b1, 16'hFFFF);
      seen.delete();
      reqs.delete();
      for (int i = 0; i < 12; i++) begin
         cycle(1'b0, 1'b0, 16'h0000);
         if (instr_valid) seen.push_back(instr_pc);
         if (imem_req) reqs.push_back(imem_addr);
      end
      chk("wrap_count", 32'(seen.size() >= 2 && reqs.size() >= 2), 32'd1);
      if (seen.size() >= 2 && reqs.size() >= 2) begin
         chk("wrap_pc0", 32'(seen[0]), 32'hFFFF);
         chk("wrap_pc1", 32'(seen[1]), 32'h0000);
         chk("wrap_req1", 32'(reqs[1]), 32'h0000);
      end

      // Randomized run with a mid-run reset.
      mem_rand = 1'b1;
      mem_wait = $urandom_range(0, 3);
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         logic        hz;
         logic        rd;
         logic [15:0] rpc;
         hz  = ($urandom_range(0, 9) < 3);
         rd  = ($urandom_range(0, 19) == 0);
         rpc = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFE + 16'($urandom_range(0, 3)))
                                           : 16'($urandom);
         cycle(hz, rd, rpc);
         if (i == 1500) do_reset();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
